// File: rtl/object_motion_engine.sv
// Multi-object position integrator that streams active objects to the draw logic each tick.
// Define OBJ_MOTION_WRAP_EN for screen wrap-around; otherwise positions saturate at the edges.
module object_motion_engine #(
  parameter int unsigned N_OBJ = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned X_W   = 9,
  parameter int unsigned Y_W   = 9,
  parameter int unsigned V_W   = 4,
  parameter int unsigned X_MAX = 320,
  parameter int unsigned Y_MAX = 240
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             ld_en,
  input  logic [IDX_W-1:0] ld_idx,
  input  logic [X_W-1:0]   ld_x,
  input  logic [Y_W-1:0]   ld_y,
  input  logic [V_W-1:0]   ld_vx,
  input  logic [V_W-1:0]   ld_vy,
  input  logic             ld_active,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [X_W-1:0]   out_x,
  output logic [Y_W-1:0]   out_y,
  output logic             busy,
  output logic             frame_done,
  output logic             overrun
);

  typedef enum logic [1:0] {StIdle, StUpdate, StEmit, StDone} state_e;

  localparam logic [IDX_W-1:0]   LastIdx = IDX_W'(N_OBJ - 1);
  localparam logic signed [X_W:0] XMax   = (X_W + 1)'(X_MAX);
  localparam logic signed [Y_W:0] YMax   = (Y_W + 1)'(Y_MAX);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [X_W-1:0]   pos_x_q [N_OBJ];
  logic [Y_W-1:0]   pos_y_q [N_OBJ];
  logic [V_W-1:0]   vel_x_q [N_OBJ];
  logic [V_W-1:0]   vel_y_q [N_OBJ];
  logic [N_OBJ-1:0] act_q;

  logic             out_valid_q;
  logic [IDX_W-1:0] out_idx_q;
  logic [X_W-1:0]   out_x_q;
  logic [Y_W-1:0]   out_y_q;
  logic             busy_q;
  logic             frame_done_q;
  logic             overrun_q;

  logic signed [X_W:0] vx_ext, sum_x;
  logic signed [Y_W:0] vy_ext, sum_y;
  logic [X_W-1:0]      new_x;
  logic [Y_W-1:0]      new_y;
  logic                clr_vx, clr_vy;
  logic                ld_hit;
  logic [IDX_W-1:0]    nxt_sel;
  logic                nxt_fwd;
  logic [X_W-1:0]      nxt_x;
  logic [Y_W-1:0]      nxt_y;
  logic                nxt_act;

  always_comb begin
    vx_ext = {{(X_W + 1 - V_W){vel_x_q[idx_q][V_W-1]}}, vel_x_q[idx_q]};
    vy_ext = {{(Y_W + 1 - V_W){vel_y_q[idx_q][V_W-1]}}, vel_y_q[idx_q]};
    sum_x  = $signed({1'b0, pos_x_q[idx_q]}) + vx_ext;
    sum_y  = $signed({1'b0, pos_y_q[idx_q]}) + vy_ext;
    new_x  = X_W'(sum_x);
    new_y  = Y_W'(sum_y);
    clr_vx = 1'b0;
    clr_vy = 1'b0;
`ifdef OBJ_MOTION_WRAP_EN
    if (sum_x < 0) begin
      new_x = X_W'(sum_x + XMax);
    end else if (sum_x >= XMax) begin
      new_x = X_W'(sum_x - XMax);
    end
    if (sum_y < 0) begin
      new_y = Y_W'(sum_y + YMax);
    end else if (sum_y >= YMax) begin
      new_y = Y_W'(sum_y - YMax);
    end
`else
    if (sum_x < 0) begin
      new_x  = '0;
      clr_vx = 1'b1;
    end else if (sum_x >= XMax) begin
      new_x  = X_W'(X_MAX - 1);
      clr_vx = 1'b1;
    end
    if (sum_y < 0) begin
      new_y  = '0;
      clr_vy = 1'b1;
    end else if (sum_y >= YMax) begin
      new_y  = Y_W'(Y_MAX - 1);
      clr_vy = 1'b1;
    end
`endif
  end

  // Next slot to present on the stream; a same-cycle load to it is forwarded.
  always_comb begin
    ld_hit  = ld_en && (int'(ld_idx) < int'(N_OBJ));
    nxt_sel = (state_q == StEmit) ? idx_q + 1'b1 : '0;
    nxt_fwd = ld_hit && (ld_idx == nxt_sel);
    nxt_x   = nxt_fwd ? ld_x : pos_x_q[nxt_sel];
    nxt_y   = nxt_fwd ? ld_y : pos_y_q[nxt_sel];
    nxt_act = nxt_fwd ? ld_active : act_q[nxt_sel];
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      act_q        <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < int'(N_OBJ); i++) begin
        pos_x_q[i] <= '0;
        pos_y_q[i] <= '0;
        vel_x_q[i] <= '0;
        vel_y_q[i] <= '0;
      end
    end else begin
      frame_done_q <= 1'b0;
      if (tick && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            state_q <= StUpdate;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StUpdate: begin
          if (act_q[idx_q]) begin
            pos_x_q[idx_q] <= new_x;
            pos_y_q[idx_q] <= new_y;
            if (clr_vx) vel_x_q[idx_q] <= '0;
            if (clr_vy) vel_y_q[idx_q] <= '0;
          end
          if (idx_q == LastIdx) begin
            state_q     <= StEmit;
            idx_q       <= '0;
            out_valid_q <= nxt_act;
            out_idx_q   <= '0;
            out_x_q     <= nxt_x;
            out_y_q     <= nxt_y;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StEmit: begin
          if (!out_valid_q || out_ready) begin
            if (idx_q == LastIdx) begin
              state_q      <= StDone;
              out_valid_q  <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              idx_q       <= nxt_sel;
              out_valid_q <= nxt_act;
              out_idx_q   <= nxt_sel;
              out_x_q     <= nxt_x;
              out_y_q     <= nxt_y;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
      // Placed last so a load beats the UPDATE write to the same slot.
      if (ld_hit) begin
        pos_x_q[ld_idx] <= ld_x;
        pos_y_q[ld_idx] <= ld_y;
        vel_x_q[ld_idx] <= ld_vx;
        vel_y_q[ld_idx] <= ld_vy;
        act_q[ld_idx]   <= ld_active;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_idx    = out_idx_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/object_motion_engine.md
Name: object_motion_engine

Overview:
- Parametrised successor to the single-ship position counter.
- Holds position, signed velocity and an active flag for N_OBJ objects (ship, asteroids, bullets).
- On each movement tick it integrates every active object with screen wrap-around, then streams the active objects' coordinates to the draw logic over a valid/ready handshake.
- Sits between the movement/control modules and the draw modules in the asteroids top level.

Parameters:
- N_OBJ, 8, number of object slots (≥2).
- IDX_W, 3, object index width; 2**IDX_W ≥ N_OBJ.
- X_W, 9, x coordinate width.
- Y_W, 9, y coordinate width.
- V_W, 4, signed two's-complement velocity width (pixels per tick).
- X_MAX, 320, screen width; legal x is 0..X_MAX-1.
- Y_MAX, 240, screen height; legal y is 0..Y_MAX-1.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset_n  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle movement strobe from the move rate divider.
- ld_en  in  1  write one object slot this cycle.
- ld_idx  in  IDX_W  slot to write.
- ld_x  in  X_W  new x position.
- ld_y  in  Y_W  new y position.
- ld_vx  in  V_W  new signed x velocity.
- ld_vy  in  V_W  new signed y velocity.
- ld_active  in  1  new active flag.
- out_valid  out  1  out_idx/out_x/out_y hold a valid object.
- out_ready  in  1  draw side accepts the current object.
- out_idx  out  IDX_W  index of the streamed object.
- out_x  out  X_W  x position of the streamed object.
- out_y  out  Y_W  y position of the streamed object.
- busy  out  1  high whenever the FSM is not in IDLE.
- frame_done  out  1  one-cycle pulse when streaming completes.
- overrun  out  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset (asynchronous, active-high): all slot positions, velocities and active flags cleared to 0. FSM goes to IDLE, index counter to 0. out_valid, out_idx, out_x, out_y, busy, frame_done and overrun all 0.
- FSM states: IDLE, UPDATE, EMIT, DONE.
- IDLE: tick → UPDATE, idx=0.
- UPDATE: one slot per cycle.
  - If the slot is active: x' = x + sign-extended vx, y' = y + sign-extended vy, computed at X_W+1 / Y_W+1 bits signed.
  - Inactive slots are left unchanged.
  - After idx = N_OBJ-1 → EMIT, idx=0. UPDATE lasts exactly N_OBJ cycles.
- Wrap rule: sum < 0 → sum + MAX; sum ≥ MAX → sum − MAX; otherwise sum. Velocity magnitude is guaranteed < MAX, so one correction always suffices.
- EMIT, inactive slot: skipped in 1 cycle with out_valid=0.
- EMIT, active slot:
  - out_valid=1 with idx/x/y of that slot, all registered.
  - Outputs are held stable until out_ready is sampled high.
  - Transfer occurs on the cycle where out_valid && out_ready; idx advances on the next edge.
  - out_valid never drops before the transfer.
- After the last slot is handled → DONE. DONE asserts frame_done for 1 cycle, then → IDLE.
- No active slots: EMIT takes N_OBJ cycles, frame_done still pulses.
- tick in any state other than IDLE is dropped and sets overrun. overrun is cleared only by reset.
- Load port:
  - Accepted in every state; written on the next clock edge.
  - If ld_idx equals the slot being written by UPDATE in the same cycle, the load wins.
  - A load to a slot already passed in EMIT takes effect next frame.
  - A load to the slot currently held in EMIT does not change out_x/out_y until after the transfer.
  - ld_idx ≥ N_OBJ is ignored.
- Reset asserted mid-frame aborts immediately: every output returns to its reset value.

Optional Feature:
- OBJ_MOTION_WRAP_EN defined: wrap-around as described above.
- Not defined: saturate instead. A sum < 0 gives 0; a sum ≥ MAX gives MAX-1, and the velocity component on that axis is cleared to 0. This lets the ship stop at the screen edge.

Test Plan:
- Reset, load slot0 (x=10, y=20, vx=+3, vy=-2, active), one tick, out_ready=1 → slot0 streamed as (13,18); frame_done exactly N_OBJ+N_OBJ+1 cycles after the tick with only slot0 active.
- Slot1 x=318, vx=+4, one tick → x=2 (wrap); with OBJ_MOTION_WRAP_EN undefined → x=319, vx reads back 0 on the next tick (x stays 319).
- Slot2 y=1, vy=-3, one tick → y=238; undefined macro → y=0.
- Slots 0, 3, 5 active, out_ready low for 5 cycles on slot3 → out_valid, out_idx=3 and out_x/out_y held stable; indices streamed 0, 3, 5 in order with no duplicates.
- tick pulsed during EMIT → ignored, overrun=1, positions advance only once; ld_en to the slot being updated in UPDATE → loaded value retained, not loaded+v.
- Reset asserted during EMIT → out_valid=0, busy=0, all slots inactive; the next tick streams nothing and frame_done still pulses.
